// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 pipeline stages: state encoding of the
// key-scheduling FSM, array size, default key length and key-byte helper.
package rc4_pkg;

  localparam int N_ENTRIES         = 256;
  localparam int KEY_BYTES_DEFAULT = 3;
  // Widest key the helper can index; callers zero-extend narrower keys.
  localparam int MAX_KEY_BYTES     = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    CAP_I,
    RD_J,
    CAP_J,
    WR_I,
    WR_J
  } ksa_state_t;

  // Big-endian byte select: idx 0 is the most significant byte of an
  // n_bytes-wide key held in the low bits of 'key'.
  function automatic logic [7:0] key_byte(
    input logic [8*MAX_KEY_BYTES-1:0] key,
    input int unsigned                n_bytes,
    input int unsigned                idx
  );
    return key[8*(n_bytes-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/ksa_if.sv
// Start handshake plus single-port S memory bus of the key-scheduling stage.
//
// Handshake: 'en' is sampled on a rising edge only while 'rdy'=1; that edge
// starts a run and latches 'key'. While 'rdy'=0, 'en' is ignored. 'rdy'
// returns to 1 when the run is complete. Memory: 'rddata' is the content
// of 'addr' one cycle after 'addr' is presented with 'wren'=0; a write
// happens on the rising edge where 'wren'=1.
interface ksa_if #(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES_DEFAULT
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  // Seen from the key-scheduling block.
  modport slave (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );

  // Seen from the controller / memory side.
  modport master (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa.sv
// RC4 key-scheduling stage. Permutes the 256-entry S memory in place:
// for i in 0..255: j += S[i] + key[i mod KEY_BYTES]; swap S[i], S[j].
// Each i takes six cycles (read i, capture, read j, capture, write i,
// write j), so a run is busy for exactly 1536 cycles.
module ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  ksa_if.slave       bus,
  output ksa_state_t o_state
);

  localparam logic [7:0] I_LAST    = 8'(N_ENTRIES - 1);
  localparam logic [7:0] KIDX_LAST = 8'(KEY_BYTES - 1);

  ksa_state_t             r_state;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [7:0]             r_si;
  logic [7:0]             r_kidx;
  logic [8*KEY_BYTES-1:0] r_key;
  logic                   r_rdy;
  logic [7:0]             r_addr;
  logic [7:0]             r_wrdata;
  logic                   r_wren;

  logic [8*MAX_KEY_BYTES-1:0] w_key_wide;
  logic [7:0]                 w_kbyte;
  logic [7:0]                 w_j_next;

  // Zero-extend the latched key to the helper's fixed width.
  always_comb begin
    w_key_wide                  = '0;
    w_key_wide[8*KEY_BYTES-1:0] = r_key;
  end

  assign w_kbyte  = key_byte(w_key_wide, int'(KEY_BYTES), 32'(r_kidx));
  // 8-bit wrap-around is the intended mod 256.
  assign w_j_next = r_j + bus.rddata + w_kbyte;

  // Sequencer: all memory-bus outputs are registered and set up one state
  // ahead, so each state's address/strobe is already on the bus during it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_si     <= 8'd0;
      r_kidx   <= 8'd0;
      r_key    <= '0;
      r_rdy    <= 1'b1;
      r_addr   <= 8'd0;
      r_wrdata <= 8'd0;
      r_wren   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wren <= 1'b0;
          if (bus.en) begin
            r_key   <= bus.key;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= 8'd0;
            r_rdy   <= 1'b0;
            r_addr  <= 8'd0;
            r_state <= RD_I;
          end
        end
        RD_I: begin
          r_state <= CAP_I;
        end
        CAP_I: begin
          r_si    <= bus.rddata;
          r_j     <= w_j_next;
          r_addr  <= w_j_next;
          r_state <= RD_J;
        end
        RD_J: begin
          r_state <= CAP_J;
        end
        CAP_J: begin
          // S[j] goes straight to the write-data register for the i write.
          r_wrdata <= bus.rddata;
          r_addr   <= r_i;
          r_wren   <= 1'b1;
          r_state  <= WR_I;
        end
        WR_I: begin
          r_wrdata <= r_si;
          r_addr   <= r_j;
          r_state  <= WR_J;
        end
        WR_J: begin
          r_wren <= 1'b0;
          r_i    <= r_i + 8'd1;
          r_kidx <= (r_kidx == KIDX_LAST) ? 8'd0 : r_kidx + 8'd1;
          if (r_i == I_LAST) begin
            // Address is left as-is while idle.
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_addr  <= r_i + 8'd1;
            r_state <= RD_I;
          end
        end
        default: begin
          r_wren  <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy    = r_rdy;
  assign bus.addr   = r_addr;
  assign bus.wrdata = r_wrdata;
  assign bus.wren   = r_wren;
  assign o_state    = r_state;

endmodule

// File: tb/tb_ksa.sv
// Bench for the RC4 key-scheduling stage: behavioural S memory, table of
// known first-write sequences, random keys against a software KSA model,
// and hand-written reset / robustness / back-to-back sequences.
module tb_ksa;
  import rc4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ksa_if #(.KEY_BYTES(3)) bus ();
  ksa_state_t w_state;

  ksa #(.KEY_BYTES(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .o_state (w_state)
  );

  // ---------------- behavioural S memory ----------------
  logic [7:0] mem [256];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [7:0]  ref_s [256];
  logic [15:0] exp_q [$];
  logic [15:0] wr_log [$];
  int          done_edge;
  int          wren_cnt;

  typedef struct {
    logic [23:0]         key;
    logic [0:3][15:0]    w;   // first four writes {addr, data}
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic ref_identity();
    for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
  endtask

  task automatic ref_ksa(input logic [23:0] k);
    int         j;
    logic [7:0] kb;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
      j  = (j + int'(ref_s[i]) + int'(kb)) % 256;
      t        = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic init_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  // Call at a negedge with rdy=1; returns at the negedge after acceptance.
  task automatic start_run(input logic [23:0] k);
    bus.en  = 1'b1;
    bus.key = k;
    @(negedge clk);
    check("accept_rdy_low", 32'(bus.rdy), 32'd0);
  endtask

  // Counts edges after acceptance until rdy is seen high again.
  task automatic wait_done(input bit hold_en, input bit poke_key);
    wr_log.delete();
    done_edge = -1;
    wren_cnt  = 0;
    if (!hold_en) bus.en = 1'b0;
    if (bus.wren) wren_cnt++;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (bus.wren) begin
        wren_cnt++;
        if (wr_log.size() < 4) wr_log.push_back({bus.addr, bus.wrdata});
      end
      if (poke_key && n == 700) bus.key = 24'hFFFFFF;
      if (bus.rdy) begin
        done_edge = n;
        break;
      end
    end
    check("latency", 32'(done_edge), 32'd1536);
    check("wren_count", 32'(wren_cnt), 32'd512);
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic check_perm();
    bit seen [256];
    int missing;
    missing = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) seen[mem[k]] = 1'b1;
    for (int k = 0; k < 256; k++) if (!seen[k]) missing++;
    check("permutation", 32'(missing), 32'd0);
  endtask

  task automatic check_first_writes(input vec_t v);
    exp_q.delete();
    for (int w = 0; w < 4; w++) exp_q.push_back(v.w[w]);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("first_wr%0d_key%06h", w, v.key),
            32'((w < wr_log.size()) ? wr_log[w] : 16'hXXXX), 32'(exp_q[w]));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [23:0] rk;
    logic [23:0] ka;
    logic [23:0] kb;

    vecs[0] = '{key: 24'h000000, w: {16'h0000, 16'h0000, 16'h0101, 16'h0101}};
    vecs[1] = '{key: 24'h00033C, w: {16'h0000, 16'h0000, 16'h0104, 16'h0401}};
    vecs[2] = '{key: 24'hFF0000, w: {16'h00FF, 16'hFF00, 16'h01FF, 16'h0001}};
    vecs[3] = '{key: 24'h010203, w: {16'h0001, 16'h0100, 16'h0103, 16'h0300}};

    bus.en   = 1'b0;
    bus.key  = 24'h0;
    mem_init = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rdy",    32'(bus.rdy),    32'd1);
    check("rst_wren",   32'(bus.wren),   32'd0);
    check("rst_addr",   32'(bus.addr),   32'd0);
    check("rst_wrdata", 32'(bus.wrdata), 32'd0);
    check("rst_state",  32'(w_state),    32'(IDLE));
    rst_n = 1'b1;

    // Table-driven known keys
    for (int v = 0; v < 4; v++) begin
      init_mem();
      ref_identity();
      ref_ksa(vecs[v].key);
      start_run(vecs[v].key);
      wait_done(1'b0, 1'b0);
      check_first_writes(vecs[v]);
      check_mem($sformatf("final_mem_key%06h", vecs[v].key));
      check_perm();
    end

    // Random keys
    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom_range(32'h00FF_FFFF, 0));
      init_mem();
      ref_identity();
      ref_ksa(rk);
      start_run(rk);
      wait_done(1'b0, 1'b0);
      check_mem($sformatf("rand_mem_key%06h", rk));
    end

    // en held high, key changed mid-run
    ka = 24'h5A17C3;
    init_mem();
    ref_identity();
    ref_ksa(ka);
    start_run(ka);
    wait_done(1'b1, 1'b1);
    bus.en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("single_run_rdy", 32'(bus.rdy), 32'd1);
    end
    check_mem("held_en_mem");

    // Back-to-back: second run accepted the cycle rdy rises
    ka = 24'h123456;
    kb = 24'hA0B1C2;
    init_mem();
    ref_identity();
    ref_ksa(ka);
    ref_ksa(kb);
    start_run(ka);
    wait_done(1'b0, 1'b0);
    start_run(kb);
    wait_done(1'b0, 1'b0);
    check_mem("b2b_mem");

    // Reset mid-run at i around 100, then a clean run
    init_mem();
    start_run(24'hC0FFEE);
    bus.en = 1'b0;
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy",   32'(bus.rdy),  32'd1);
    check("midrst_wren",  32'(bus.wren), 32'd0);
    check("midrst_addr",  32'(bus.addr), 32'd0);
    check("midrst_state", 32'(w_state),  32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    init_mem();
    ref_identity();
    ref_ksa(vecs[1].key);
    start_run(vecs[1].key);
    wait_done(1'b0, 1'b0);
    check_first_writes(vecs[1]);
    check_mem("after_rst_mem");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
